// File: rtl/seq_subtractor8_pkg.sv
// rtl/seq_subtractor8_pkg.sv - shared types and constants for the sequential subtractor
package seq_subtractor8_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DIGIT = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Number of compute cycles needed to resolve a WIDTH-bit operand DIGIT bits at a time.
   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

endpackage

// File: rtl/seq_subtractor8_full_subtractor.sv
// rtl/seq_subtractor8_full_subtractor.sv - one-bit full subtractor cell of the borrow chain
module seq_subtractor8_full_subtractor (
   input  logic x_i,
   input  logic y_i,
   input  logic bin_i,
   output logic d_o,
   output logic bout_o
);

   assign d_o    = x_i ^ y_i ^ bin_i;
   assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/seq_subtractor8.sv
// rtl/seq_subtractor8.sv - multi-cycle ripple-borrow subtractor; SEQ_SUBTRACTOR8_ADDSUB_EN adds an add mode
module seq_subtractor8
   import seq_subtractor8_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] Xi,
   input  logic [WIDTH-1:0] Yi,
   input  logic             B0,
`ifdef SEQ_SUBTRACTOR8_ADDSUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Di,
   output logic             B8,
   output logic             V
);

   // WIDTH must be at least two digits so the partial-difference register is non-empty.
   localparam int N     = num_digits(WIDTH, DIGIT);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int PW    = WIDTH - DIGIT;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   x_q, y_q;
   logic [PW-1:0]      part_q;
   logic               borrow_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               xmsb_q, ymsb_q, sub_q;
   logic [WIDTH-1:0]   di_q;
   logic               b8_q, v_q;

   logic               sub_in;
   logic               accept;
   logic               last;
   logic [DIGIT-1:0]   dig;
   logic [DIGIT:0]     bch;
   logic [WIDTH-1:0]   part_d;

   // In add mode Y is inverted and the borrow chain is run with an inverted
   // borrow-in; the final borrow-out is then the complement of the carry-out.
`ifdef SEQ_SUBTRACTOR8_ADDSUB_EN
   assign sub_in = sub;
`else
   assign sub_in = 1'b1;
`endif

   assign accept = start & (state_q != RUN);
   assign last   = (state_q == RUN) && (cnt_q == CNT_W'(N - 1));

   assign bch[0] = borrow_q;

   genvar g;
   generate
      for (g = 0; g < DIGIT; g++) begin : g_chain
         seq_subtractor8_full_subtractor u_fs (
            .x_i    (x_q[g]),
            .y_i    (y_q[g]),
            .bin_i  (bch[g]),
            .d_o    (dig[g]),
            .bout_o (bch[g+1])
         );
      end
   endgenerate

   // Newest digit enters at the top; after N digits the low digit sits at bit 0.
   assign part_d = {dig, part_q};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; DONE accepts a new start directly for back-to-back operation.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand latch, per-digit shift, and result registers updated only on completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q      <= '0;
         y_q      <= '0;
         part_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         xmsb_q   <= 1'b0;
         ymsb_q   <= 1'b0;
         sub_q    <= 1'b0;
         di_q     <= '0;
         b8_q     <= 1'b0;
         v_q      <= 1'b0;
      end else if (accept) begin
         x_q      <= Xi;
         y_q      <= sub_in ? Yi : ~Yi;
         borrow_q <= sub_in ? B0 : ~B0;
         xmsb_q   <= Xi[WIDTH-1];
         ymsb_q   <= sub_in ? Yi[WIDTH-1] : ~Yi[WIDTH-1];
         sub_q    <= sub_in;
         cnt_q    <= '0;
         part_q   <= '0;
      end else if (state_q == RUN) begin
         x_q      <= x_q >> DIGIT;
         y_q      <= y_q >> DIGIT;
         borrow_q <= bch[DIGIT];
         part_q   <= part_d[WIDTH-1:DIGIT];
         cnt_q    <= cnt_q + 1'b1;
         if (last) begin
            di_q <= part_d;
            b8_q <= sub_q ? bch[DIGIT] : ~bch[DIGIT];
            // With Y pre-inverted in add mode, the subtract overflow rule
            // on the latched operands yields the add overflow rule.
            v_q  <= (xmsb_q != ymsb_q) & (part_d[WIDTH-1] != xmsb_q);
         end
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign Di   = di_q;
   assign B8   = b8_q;
   assign V    = v_q;

endmodule
